// File: rtl/pattern_repeat_detector.sv
// Searches a valid-qualified word stream for a PAT_WORDS-word pattern and
// reports lock once the pattern has repeated n_repeats times back-to-back.
module pattern_repeat_detector #(
   parameter int DATA_W    = 8,
   parameter int PAT_WORDS = 4,
   parameter int CNT_W     = 8,
   parameter bit STICKY    = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          clear,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             data_in,
   input  logic [DATA_W*PAT_WORDS-1:0]   pattern,
   input  logic [CNT_W-1:0]              n_repeats,
   output logic                          pattern_found,
   output logic                          match_pulse,
   output logic [CNT_W-1:0]              repeat_count,
   output logic                          busy
);

   // state | meaning
   // IDLE  | waiting for word 0 of the pattern
   // MATCH | partway through an instance, or between consecutive instances
   // FOUND | lock reached (held when STICKY, one cycle otherwise)
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MATCH = 2'd1,
      FOUND = 2'd2
   } state_t;

   localparam int IDX_W = (PAT_WORDS > 1) ? $clog2(PAT_WORDS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_WORDS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t            state_q;
   logic [IDX_W-1:0]  idx_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              found_q;
   logic              pulse_q;
   logic              busy_q;

   logic [DATA_W-1:0] word0;
   logic [DATA_W-1:0] cur_word;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  n_eff;

   assign word0 = pattern[DATA_W*PAT_WORDS-1 -: DATA_W];
   assign n_eff = (n_repeats == '0) ? CNT_W'(1) : n_repeats;
   assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // Word 0 sits in the most-significant slice.
   always_comb begin
      cur_word = '0;
      for (int i = 0; i < PAT_WORDS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_word = pattern[(PAT_WORDS-1-i)*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         found_q <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && data_in == word0) begin
                  state_q <= MATCH;
                  idx_q   <= IDX_ONE;
                  busy_q  <= 1'b1;
               end
            end
            MATCH: begin
               if (in_valid) begin
                  if (data_in == cur_word) begin
                     if (idx_q == IDX_LAST) begin
                        idx_q   <= '0;
                        cnt_q   <= cnt_d;
                        pulse_q <= 1'b1;
                        if (cnt_d >= n_eff) begin
                           state_q <= FOUND;
                           found_q <= 1'b1;
                        end
                     end else begin
                        idx_q <= idx_q + IDX_ONE;
                     end
                  end else begin
                     // A broken run restarts immediately if the bad word is word 0.
                     cnt_q <= '0;
                     if (data_in == word0) begin
                        idx_q <= IDX_ONE;
                     end else begin
                        state_q <= IDLE;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                     end
                  end
               end
            end
            FOUND: begin
               if (!STICKY) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
                  cnt_q   <= '0;
                  found_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
               cnt_q   <= '0;
               found_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pattern_found = found_q;
   assign match_pulse   = pulse_q;
   assign repeat_count  = cnt_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_pattern_repeat_detector.sv
// Directed-vector bench for pattern_repeat_detector: one sticky and one pulse
// instance share the stimulus; each vector names the instance it checks.
module tb_pattern_repeat_detector;

   localparam int DW = 8;
   localparam int PW = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clear;
   logic          in_valid;
   logic [DW-1:0] data_in;
   logic [DW*PW-1:0] pattern;
   logic [CW-1:0] n_repeats;

   logic          st_found, st_pulse, st_busy;
   logic [CW-1:0] st_cnt;
   logic          pl_found, pl_pulse, pl_busy;
   logic [CW-1:0] pl_cnt;

   always #5 clk = ~clk;

   pattern_repeat_detector #(.DATA_W(DW), .PAT_WORDS(PW), .CNT_W(CW), .STICKY(1'b1)) u_st (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
      .pattern(pattern), .n_repeats(n_repeats), .pattern_found(st_found),
      .match_pulse(st_pulse), .repeat_count(st_cnt), .busy(st_busy)
   );

   pattern_repeat_detector #(.DATA_W(DW), .PAT_WORDS(PW), .CNT_W(CW), .STICKY(1'b0)) u_pl (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
      .pattern(pattern), .n_repeats(n_repeats), .pattern_found(pl_found),
      .match_pulse(pl_pulse), .repeat_count(pl_cnt), .busy(pl_busy)
   );

   typedef struct {
      logic          v;
      logic          clr;
      logic [DW-1:0] d;
      logic [CW-1:0] n;
      logic          sel;   // 0 = sticky instance, 1 = pulse instance
      logic          ef;
      logic          ep;
      logic [CW-1:0] ec;
      logic          eb;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [DW-1:0] pword(int w);
      case (w)
         0:       return 8'hDE;
         1:       return 8'hAD;
         2:       return 8'hBE;
         default: return 8'hEF;
      endcase
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_out(string tag, logic sel, logic ef, logic ep, logic [CW-1:0] ec, logic eb);
      if (sel == 1'b0) begin
         chk({tag, " found"}, 32'(st_found), 32'(ef));
         chk({tag, " pulse"}, 32'(st_pulse), 32'(ep));
         chk({tag, " count"}, 32'(st_cnt),   32'(ec));
         chk({tag, " busy"},  32'(st_busy),  32'(eb));
      end else begin
         chk({tag, " found"}, 32'(pl_found), 32'(ef));
         chk({tag, " pulse"}, 32'(pl_pulse), 32'(ep));
         chk({tag, " count"}, 32'(pl_cnt),   32'(ec));
         chk({tag, " busy"},  32'(pl_busy),  32'(eb));
      end
   endtask

   task automatic add(logic v, logic clr, logic [DW-1:0] d, logic [CW-1:0] n, logic sel,
                      logic ef, logic ep, logic [CW-1:0] ec, logic eb);
      vec_t r;
      r.v = v; r.clr = clr; r.d = d; r.n = n; r.sel = sel;
      r.ef = ef; r.ep = ep; r.ec = ec; r.eb = eb;
      vq.push_back(r);
   endtask

   task automatic add_clear(logic [CW-1:0] n, logic sel);
      add(1'b0, 1'b1, 8'h00, n, sel, 1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   // One full back-to-back instance; base is the count held before it starts.
   task automatic add_inst(logic [CW-1:0] n, logic sel, logic [CW-1:0] base, logic lock);
      for (int w = 0; w < PW; w++) begin
         if (w == PW - 1) add(1'b1, 1'b0, pword(w), n, sel, lock, 1'b1, base + 8'd1, 1'b1);
         else             add(1'b1, 1'b0, pword(w), n, sel, 1'b0, 1'b0, base, 1'b1);
      end
   endtask

   // Drive at #1 after a rising edge, then sample #1 after the next one.
   task automatic step(logic v, logic clr, logic [DW-1:0] d, logic [CW-1:0] n);
      in_valid  = v;
      clear     = clr;
      data_in   = d;
      n_repeats = n;
      @(posedge clk);
      #1;
   endtask

   initial begin
      pattern   = 32'hDEADBEEF;
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      data_in   = '0;
      n_repeats = 8'd3;

      // Test 1: three back-to-back instances, sticky lock, then clear in FOUND
      add_clear(8'd3, 1'b0);
      add_inst(8'd3, 1'b0, 8'd0, 1'b0);
      add_inst(8'd3, 1'b0, 8'd1, 1'b0);
      add_inst(8'd3, 1'b0, 8'd2, 1'b1);
      add(1'b1, 1'b0, 8'hDE, 8'd3, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1);
      add(1'b0, 1'b0, 8'h00, 8'd3, 1'b0, 1'b1, 1'b0, 8'd3, 1'b1);
      add(1'b1, 1'b1, 8'hDE, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Test 2: in_valid toggling; idle cycles hold state and drop the pulse
      add_clear(8'd3, 1'b0);
      for (int r = 0; r < 3; r++) begin
         for (int w = 0; w < PW; w++) begin
            logic          last;
            logic [CW-1:0] c;
            last = (w == PW - 1);
            c    = CW'(r) + (last ? 8'd1 : 8'd0);
            add(1'b1, 1'b0, pword(w), 8'd3, 1'b0, last && r == 2, last, c, 1'b1);
            add(1'b0, 1'b0, 8'hEF,    8'd3, 1'b0, last && r == 2, 1'b0, c, 1'b1);
         end
      end

      // Test 3a: broken second instance drops count, fresh instance counts 1
      add_clear(8'd3, 1'b0);
      add_inst(8'd3, 1'b0, 8'd0, 1'b0);
      add(1'b1, 1'b0, 8'hDE, 8'd3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
      add(1'b1, 1'b0, 8'hAD, 8'd3, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1);
      add(1'b1, 1'b0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      add_inst(8'd3, 1'b0, 8'd0, 1'b0);
      // Test 3b: DE where BE is expected resyncs to a new attempt
      add_clear(8'd3, 1'b0);
      add(1'b1, 1'b0, 8'hDE, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      add(1'b1, 1'b0, 8'hAD, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      add_inst(8'd3, 1'b0, 8'd0, 1'b0);

      // Test 4: n_repeats of 0 locks after one instance
      add_clear(8'd0, 1'b0);
      add_inst(8'd0, 1'b0, 8'd0, 1'b1);

      // Test 5: pulse mode, n=2; an idle cycle covers the FOUND cycle
      add_clear(8'd2, 1'b1);
      add_inst(8'd2, 1'b1, 8'd0, 1'b0);
      add_inst(8'd2, 1'b1, 8'd1, 1'b1);
      add(1'b0, 1'b0, 8'h00, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      add_inst(8'd2, 1'b1, 8'd0, 1'b0);
      add_inst(8'd2, 1'b1, 8'd1, 1'b1);
      // word presented during FOUND is dropped, so the next AD finds IDLE
      add(1'b1, 1'b0, 8'hDE, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      add(1'b1, 1'b0, 8'hAD, 8'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);

      // Test 6a: clear mid-instance also resets the word index
      add_clear(8'd3, 1'b0);
      add(1'b1, 1'b0, 8'hDE, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      add(1'b1, 1'b0, 8'hAD, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
      add_clear(8'd3, 1'b0);
      add(1'b1, 1'b0, 8'hBE, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

      // Reset state
      #2;
      check_out("reset st", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      check_out("reset pl", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].v, vq[i].clr, vq[i].d, vq[i].n);
         check_out($sformatf("vec%0d", i), vq[i].sel, vq[i].ef, vq[i].ep, vq[i].ec, vq[i].eb);
      end

      // Test 6b: async reset while in sticky FOUND, then relock
      for (int r = 0; r < 3; r++)
         for (int w = 0; w < PW; w++) step(1'b1, 1'b0, pword(w), 8'd3);
      check_out("prelock", 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async rst", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int r = 0; r < 3; r++)
         for (int w = 0; w < PW; w++) step(1'b1, 1'b0, pword(w), 8'd3);
      check_out("relock", 1'b0, 1'b1, 1'b1, 8'd3, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'd3);
      check_out("relock hold", 1'b0, 1'b1, 1'b0, 8'd3, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pattern_repeat_detector.md
Name: pattern_repeat_detector

Overview:
Parametrised successor of the byte-stream pattern detector used in the PRBS checker path. Watches a word stream qualified by a valid strobe and searches for a PAT_WORDS-word pattern. Flags lock when the pattern has occurred n_repeats times back-to-back. Adds generic word width and pattern length, valid gating, a synchronous clear, sticky or pulse reporting, a per-instance match pulse and a live repeat count.

Parameters:
DATA_W, 8, width of one stream word (bits)
PAT_WORDS, 4, pattern length in words (≥2)
CNT_W, 8, width of n_repeats and repeat_count
STICKY, 1, 1 = pattern_found held until clear/reset; 0 = one-cycle pulse, then search resumes

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous, active-low reset
clear  in  1  synchronous clear; returns block to reset state next edge
in_valid  in  1  data_in is consumed only on cycles where this is 1
data_in  in  DATA_W  stream word
pattern  in  DATA_W*PAT_WORDS  pattern; word 0 = MS slice, compared first
n_repeats  in  CNT_W  required consecutive instances; 0 treated as 1
pattern_found  out  1  lock indication (registered)
match_pulse  out  1  one-cycle pulse per completed pattern instance (registered)
repeat_count  out  CNT_W  consecutive complete instances seen so far (registered)
busy  out  1  1 when state ≠ IDLE (registered)

Behaviour:
- Reset values (rst_n low or clear high): state IDLE, word index 0, repeat_count 0, pattern_found 0, match_pulse 0, busy 0. clear has priority over in_valid; it also applies mid-pattern and in FOUND.
- Cycles with in_valid=0: no state, index or count change. match_pulse is 0 on those cycles.
- pattern and n_repeats are compared live. They must be stable while busy=1; changing them mid-search is undefined.
- Single FSM with states IDLE, MATCH, FOUND. The word index (0..PAT_WORDS-1) is a separate counter.
- IDLE, valid word:
  - If data_in == word 0: go to MATCH with index 1.
  - Otherwise stay in IDLE.
  - repeat_count stays 0 in IDLE.
- MATCH, valid word, data_in == word[index]:
  - If index < PAT_WORDS-1: increment index.
  - If index == PAT_WORDS-1 (instance complete): index → 0, repeat_count +1 (saturating at all-ones), match_pulse=1 next cycle.
  - If the incremented count ≥ max(n_repeats,1): go to FOUND and assert pattern_found on the same edge.
- MATCH, valid word, mismatch (resync rule):
  - repeat_count → 0.
  - If data_in == word 0: stay in MATCH with index 1, starting a new attempt.
  - Otherwise go to IDLE with index 0.
  - Repeats must be strictly consecutive; no gap words are allowed between instances.
- FOUND with STICKY=1: input ignored; pattern_found=1, repeat_count frozen, busy=1. Only clear or reset exits.
- FOUND with STICKY=0: FOUND lasts exactly one cycle, so pattern_found is a one-cycle pulse. On the next edge go to IDLE, index 0, repeat_count 0. A valid word in that cycle is ignored.
- Latency: pattern_found and match_pulse rise on the clock edge that samples the final word of the qualifying instance, i.e. they are visible in the cycle after that word is presented.
- Overlap: self-overlapping patterns are not tracked beyond the word-0 resync rule. For example, with pattern AA AA AA BB, the stream AA AA AA AA BB is a miss.
- No combinational path from inputs to outputs; all outputs come straight from flops.

Test Plan:
1. DATA_W=8, PAT_WORDS=4, pattern=0xDEADBEEF, n_repeats=3. Feed DE AD BE EF ×3 with in_valid=1 every cycle → match_pulse at words 4, 8 and 12; repeat_count 1, 2, 3; pattern_found=1 the cycle after word 12 and held (STICKY=1).
2. Same config, in_valid toggled 1/0 every cycle while feeding the same words → identical result, with all events delayed to the valid-word timing.
3. Feed DE AD BE EF DE AD 00 DE AD BE EF → repeat_count drops to 0 at the 00 word and is 1 at the end; pattern_found stays 0. Feed DE AD DE AD BE EF → the mismatching DE resyncs and the instance completes, repeat_count=1.
4. n_repeats=0, single DEADBEEF → pattern_found=1 after word 4 (0 treated as 1).
5. STICKY=0, n_repeats=2, feed the pattern ×4 → pattern_found pulses for exactly one cycle after instance 2. Search restarts: instance 3 gives repeat_count=1, and a second one-cycle pulse follows instance 4.
6. Assert clear mid-instance (after DE AD), then assert rst_n low while in FOUND → all outputs 0 next edge, or immediately for rst_n. A full new sequence then locks normally.
